// File: rtl/relu_maxpool2x2.sv
// ReLU followed by a 2x2 stride-2 max-pool over nok conv channels in lockstep.
// Top-row pixel pairs are kept in a half-row line buffer until the bottom row completes each window.
module relu_maxpool2x2 #(
  parameter int N   = 7,
  parameter int nok = 3,
  parameter int im  = 28
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [nok*(2*N+2)-1:0]    in_data,
  input  logic                      in_valid,
  input  logic                      conv_fin,
  input  logic [11:0]               row_len,
  output logic [nok*(2*N+2)-1:0]    out,
  output logic                      out_valid,
  output logic [11:0]               out_idx,
  output logic                      frame_done
);

  localparam int W   = 2*N + 2;
  localparam int LB  = im / 2;
  localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

  typedef enum logic [1:0] {IDLE, TOP, BOT, DONE} state_t;

  state_t               state_q, state_d;
  logic [11:0]          rl_q, rl_d;
  logic [11:0]          col_q, col_d;
  logic [11:0]          row_q, row_d;
  logic [W-1:0]         hold_q [nok];
  logic [W-1:0]         hold_d [nok];
  logic [nok*W-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic [11:0]          out_idx_q, out_idx_d;
  logic                 frame_done_q, frame_done_d;

  // Not reset: every entry is rewritten in TOP before BOT reads it.
  logic [W-1:0]         linebuf_q [nok][LB];

  logic [11:0]          curCol, curRl, curRow;
  logic                 curBot, lastCol, inRange, lbWe;
  logic [LBW-1:0]       lbIdx;
  logic [W-1:0]         pix    [nok];
  logic [W-1:0]         pair   [nok];
  logic [W-1:0]         pooled [nok];

  // In IDLE the first pixel is handled as column 0 of a fresh top row.
  always_comb begin
    curCol  = (state_q == IDLE) ? 12'd0 : col_q;
    curRl   = (state_q == IDLE) ? row_len : rl_q;
    curRow  = (state_q == IDLE) ? 12'd0 : row_q;
    curBot  = (state_q == BOT);
    lastCol = ({1'b0, curCol} + 13'd1) >= {1'b0, curRl};
    inRange = curCol < 12'(im);
    lbIdx   = curCol[LBW:1];
    for (int c = 0; c < nok; c++) begin
      pix[c]    = in_data[c*W + W-1] ? '0 : in_data[c*W +: W];
      pair[c]   = (hold_q[c] > pix[c]) ? hold_q[c] : pix[c];
      pooled[c] = (linebuf_q[c][lbIdx] > pair[c]) ? linebuf_q[c][lbIdx] : pair[c];
    end
  end

  always_comb begin
    state_d      = state_q;
    rl_d         = rl_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    out_idx_d    = out_idx_q;
    lbWe         = 1'b0;

    if (out_valid_q) begin
      out_idx_d = out_idx_q + 12'd1;
    end

    if (in_valid && (state_q != DONE)) begin
      if (state_q == IDLE) begin
        rl_d = row_len;
      end
      if (!curCol[0]) begin
        for (int c = 0; c < nok; c++) hold_d[c] = pix[c];
      end else if (inRange) begin
        if (curBot) begin
          for (int c = 0; c < nok; c++) out_d[c*W +: W] = pooled[c];
          out_valid_d = 1'b1;
        end else begin
          lbWe = 1'b1;
        end
      end
      if (lastCol) begin
        col_d   = 12'd0;
        row_d   = curRow + 12'd1;
        state_d = curBot ? TOP : BOT;
      end else begin
        col_d   = curCol + 12'd1;
        row_d   = curRow;
        state_d = curBot ? BOT : TOP;
      end
    end

    case (state_q)
      TOP, BOT: begin
        if (conv_fin) state_d = DONE;
      end
      DONE: begin
        state_d   = IDLE;
        out_idx_d = 12'd0;
        col_d     = 12'd0;
        row_d     = 12'd0;
      end
      default: ;
    endcase

    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rl_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      frame_done_q <= 1'b0;
      for (int c = 0; c < nok; c++) hold_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      rl_q         <= rl_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      frame_done_q <= frame_done_d;
      for (int c = 0; c < nok; c++) hold_q[c] <= hold_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (lbWe) begin
      for (int c = 0; c < nok; c++) linebuf_q[c][lbIdx] <= pair[c];
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Scoreboard bench for relu_maxpool2x2: expected windows are queued while pixels are driven
// and compared against what a negedge monitor captures from the pooled output.
module tb_relu_maxpool2x2;

  localparam int W   = 16;
  localparam int NOK = 3;
  localparam int IM  = 28;

  logic              clk = 1'b0;
  logic              reset;
  logic [NOK*W-1:0]  in_data;
  logic              in_valid;
  logic              conv_fin;
  logic [11:0]       row_len;
  logic [NOK*W-1:0]  out;
  logic              out_valid;
  logic [11:0]       out_idx;
  logic              frame_done;

  int assertCount = 0;
  int failCount   = 0;

  logic [W-1:0]      pixMem [NOK][IM][IM];
  logic [NOK*W-1:0]  expOut[$];
  int                expIdx[$];
  logic [NOK*W-1:0]  gotOut[$];
  int                gotIdx[$];
  int                fdCount = 0;

  relu_maxpool2x2 #(.N(7), .nok(NOK), .im(IM)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .conv_fin   (conv_fin),
    .row_len    (row_len),
    .out        (out),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        gotOut.push_back(out);
        gotIdx.push_back(int'(out_idx));
      end
      if (frame_done) fdCount++;
    end
  end

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    return v[W-1] ? '0 : v;
  endfunction

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic fillRandom();
    for (int ch = 0; ch < NOK; ch++)
      for (int r = 0; r < IM; r++)
        for (int c = 0; c < IM; c++)
          pixMem[ch][r][c] = W'($urandom);
  endtask

  // Drives a frame in raster order; the window expectation is queued on its bottom-right pixel.
  task automatic runFrame(input int rl, input int rows, input int gap, input bit finWithLast, input int maxPix);
    int nextIdx = 0;
    int count = 0;
    logic [NOK*W-1:0] e;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < rl; c++) begin
        if (maxPix >= 0 && count == maxPix) return;
        repeat (gap) @(posedge clk);
        #1;
        row_len  = 12'(rl);
        in_valid = 1'b1;
        conv_fin = finWithLast && (r == rows-1) && (c == rl-1);
        for (int ch = 0; ch < NOK; ch++) in_data[ch*W +: W] = pixMem[ch][r][c];
        if (r[0] && c[0] && c < IM) begin
          for (int ch = 0; ch < NOK; ch++)
            e[ch*W +: W] = max2(max2(relu(pixMem[ch][r-1][c-1]), relu(pixMem[ch][r-1][c])),
                                max2(relu(pixMem[ch][r][c-1]), relu(pixMem[ch][r][c])));
          expOut.push_back(e);
          expIdx.push_back(nextIdx);
          nextIdx++;
        end
        count++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        conv_fin = 1'b0;
      end
    end
    if (!finWithLast) begin
      conv_fin = 1'b1;
      @(posedge clk);
      #1;
      conv_fin = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    reset    = 1'b1;
    in_valid = 1'b0;
    conv_fin = 1'b0;
    row_len  = 12'd0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    assertCount++;
    if (out !== '0) begin failCount++; $display("[TB] FAIL reset_out got %h want 0", out); end
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    assertCount++;
    if (out_idx !== 12'd0) begin failCount++; $display("[TB] FAIL reset_out_idx got %0d want 0", out_idx); end
    assertCount++;
    if (frame_done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic(input int gap, input string tag);
    int b = gotOut.size();
    int fb = fdCount;
    int want0[4] = '{5, 7, 13, 15};
    expOut.delete(); expIdx.delete();
    fillRandom();
    for (int i = 0; i < 16; i++) pixMem[0][i/4][i%4] = W'(i);
    runFrame(4, 4, gap, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 4) begin failCount++; $display("[TB] FAIL %s_count got %0d want 4", tag, gotOut.size() - b); end
    for (int k = 0; k < 4 && b + k < gotOut.size(); k++) begin
      assertCount++;
      if (gotOut[b+k][W-1:0] !== W'(want0[k])) begin
        failCount++; $display("[TB] FAIL %s_ch0[%0d] got %0d want %0d", tag, k, gotOut[b+k][W-1:0], want0[k]);
      end
      assertCount++;
      if (gotOut[b+k] !== expOut[k]) begin failCount++; $display("[TB] FAIL %s_all[%0d] got %h want %h", tag, k, gotOut[b+k], expOut[k]); end
      assertCount++;
      if (gotIdx[b+k] !== k) begin failCount++; $display("[TB] FAIL %s_idx[%0d] got %0d want %0d", tag, k, gotIdx[b+k], k); end
    end
    assertCount++;
    if (fdCount - fb !== 1) begin failCount++; $display("[TB] FAIL %s_frame_done got %0d want 1", tag, fdCount - fb); end
    assertCount++;
    if (out[W-1:0] !== W'(15)) begin failCount++; $display("[TB] FAIL %s_out_hold got %0d want 15", tag, out[W-1:0]); end
  endtask

  task automatic test_relu();
    int b = gotOut.size();
    int fb;
    expOut.delete(); expIdx.delete();
    fillRandom();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pixMem[2][r][c] = 16'hFFFB;
    runFrame(4, 4, 0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 4) begin failCount++; $display("[TB] FAIL relu_count got %0d want 4", gotOut.size() - b); end
    for (int k = 0; k < 4 && b + k < gotOut.size(); k++) begin
      assertCount++;
      if (gotOut[b+k][2*W +: W] !== '0) begin failCount++; $display("[TB] FAIL relu_ch2[%0d] got %h want 0", k, gotOut[b+k][2*W +: W]); end
      assertCount++;
      if (gotOut[b+k] !== expOut[k]) begin failCount++; $display("[TB] FAIL relu_all[%0d] got %h want %h", k, gotOut[b+k], expOut[k]); end
    end
    b = gotOut.size();
    fb = fdCount;
    expOut.delete(); expIdx.delete();
    pixMem[0][0][0] = 16'hFFFD; pixMem[0][0][1] = 16'd2;
    pixMem[0][1][0] = 16'hFFF9; pixMem[0][1][1] = 16'd1;
    runFrame(2, 2, 0, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 1) begin failCount++; $display("[TB] FAIL mixed_count got %0d want 1", gotOut.size() - b); end
    if (gotOut.size() > b) begin
      assertCount++;
      if (gotOut[b][W-1:0] !== 16'd2) begin failCount++; $display("[TB] FAIL mixed_ch0 got %0d want 2", gotOut[b][W-1:0]); end
      assertCount++;
      if (gotIdx[b] !== 0) begin failCount++; $display("[TB] FAIL mixed_idx got %0d want 0", gotIdx[b]); end
    end
    assertCount++;
    if (fdCount - fb !== 1) begin failCount++; $display("[TB] FAIL mixed_frame_done got %0d want 1", fdCount - fb); end
  endtask

  task automatic test_odd();
    int b = gotOut.size();
    int want1[4] = '{6, 8, 16, 18};
    expOut.delete(); expIdx.delete();
    fillRandom();
    for (int i = 0; i < 20; i++) pixMem[1][i/5][i%5] = W'(i);
    runFrame(5, 4, 0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 4) begin failCount++; $display("[TB] FAIL odd_col_count got %0d want 4", gotOut.size() - b); end
    for (int k = 0; k < 4 && b + k < gotOut.size(); k++) begin
      assertCount++;
      if (gotOut[b+k][W +: W] !== W'(want1[k])) begin
        failCount++; $display("[TB] FAIL odd_col_ch1[%0d] got %0d want %0d", k, gotOut[b+k][W +: W], want1[k]);
      end
    end
    b = gotOut.size();
    expOut.delete(); expIdx.delete();
    fillRandom();
    runFrame(4, 3, 0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 2) begin failCount++; $display("[TB] FAIL odd_row_count got %0d want 2", gotOut.size() - b); end
    for (int k = 0; k < 2 && b + k < gotOut.size(); k++) begin
      assertCount++;
      if (gotOut[b+k] !== expOut[k]) begin failCount++; $display("[TB] FAIL odd_row_all[%0d] got %h want %h", k, gotOut[b+k], expOut[k]); end
    end
  endtask

  task automatic test_full(input string tag);
    int b = gotOut.size();
    int fb = fdCount;
    int bad = 0;
    expOut.delete(); expIdx.delete();
    fillRandom();
    runFrame(28, 28, 0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 196) begin failCount++; $display("[TB] FAIL %s_count got %0d want 196", tag, gotOut.size() - b); end
    for (int k = 0; k < expOut.size() && b + k < gotOut.size(); k++) begin
      if (bad < 8) begin
        assertCount++;
        if (gotOut[b+k] !== expOut[k] || gotIdx[b+k] !== expIdx[k]) begin
          failCount++; bad++;
          $display("[TB] FAIL %s_pix[%0d] got %h@%0d want %h@%0d", tag, k, gotOut[b+k], gotIdx[b+k], expOut[k], expIdx[k]);
        end
      end
    end
    assertCount++;
    if (fdCount - fb !== 1) begin failCount++; $display("[TB] FAIL %s_frame_done got %0d want 1", tag, fdCount - fb); end
  endtask

  task automatic test_reset_mid();
    expOut.delete(); expIdx.delete();
    fillRandom();
    runFrame(28, 28, 0, 1'b0, 10);
    reset = 1'b1;
    #1;
    assertCount++;
    if (out !== '0 || out_valid !== 1'b0 || out_idx !== 12'd0 || frame_done !== 1'b0) begin
      failCount++; $display("[TB] FAIL midreset_outputs got %h/%b/%0d/%b want 0", out, out_valid, out_idx, frame_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_full("midreset_frame");
  endtask

  task automatic test_idle_fin();
    int b = gotOut.size();
    int fb = fdCount;
    conv_fin = 1'b1;
    @(posedge clk);
    #1;
    conv_fin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if (fdCount - fb !== 0) begin failCount++; $display("[TB] FAIL idle_fin got %0d want 0", fdCount - fb); end
    expOut.delete(); expIdx.delete();
    fillRandom();
    runFrame(1, 4, 0, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    assertCount++;
    if (gotOut.size() - b !== 0) begin failCount++; $display("[TB] FAIL short_row_count got %0d want 0", gotOut.size() - b); end
    assertCount++;
    if (fdCount - fb !== 1) begin failCount++; $display("[TB] FAIL short_row_frame_done got %0d want 1", fdCount - fb); end
  endtask

  task automatic checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
  endtask

  initial begin
    applyStimulus();
    test_reset();
    test_basic(0, "basic");
    test_relu();
    test_basic(2, "gaps");
    test_odd();
    test_full("full");
    test_reset_mid();
    test_idle_fin();
    checkOutput();
    $finish;
  end

endmodule

// File: doc/relu_maxpool2x2.md
RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

Interface
REQ-001 Parameter N, default 7: input pixel width is N+1; conv result width W = 2N+2 = 16 bits, two's-complement signed.
REQ-002 Parameter nok, default 3: number of parallel feature-map channels.
REQ-003 Parameter im, default 28: maximum conv-map row length; sets line-buffer depth im/2 per channel.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_data  input  [W-1:0] x nok  conv results, one per channel, in raster order.
REQ-007 in_valid  input  1  in_data holds one new pixel this cycle.
REQ-008 conv_fin  input  1  upstream frame complete; level or pulse.
REQ-009 row_len  input  12  conv-map row length; sampled at frame start.
REQ-010 out  output  [W-1:0] x nok  pooled, rectified result per channel.
REQ-011 out_valid  output  1  one-cycle pulse per pooled pixel.
REQ-012 out_idx  output  12  raster index of the current pooled pixel, starting at 0 each frame.
REQ-013 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-014 Each channel SHALL apply ReLU on input: negative values (MSB=1) become 0; others pass unchanged.
REQ-015 SHALL compute a 2x2 max-pool, stride 2, over the rectified map, all channels in lockstep.
REQ-016 FSM states: IDLE, TOP (even row), BOT (odd row), DONE.
REQ-017 IDLE: first in_valid latches row_len into rl, sets col=0 and row=0, consumes that pixel, and enters TOP.
REQ-018 col SHALL increment per in_valid; at col=rl-1, col wraps to 0 and the state toggles TOP<->BOT.
REQ-019 Cycles with in_valid=0 SHALL not change counters, buffers or outputs; gaps of any length are legal.
REQ-020 Even col: hold register stores the rectified pixel.
REQ-021 Odd col: pair = max(hold, pixel).
REQ-022 In TOP, pair SHALL be written to linebuf[col>>1].
REQ-023 In BOT, out SHALL be registered as max(linebuf[col>>1], pair), with out_valid high for exactly the next cycle.
REQ-024 Latency: out_valid rises on the clock edge after the in_valid cycle of each 2x2 window's bottom-right pixel.
REQ-025 out_idx SHALL increment after each out_valid and hold its value between pulses.
REQ-026 out SHALL hold its last value when out_valid is low.
REQ-027 Odd rl: the last column of each row SHALL be ignored, not written or output.
REQ-028 Odd row count: the final unpaired row SHALL produce no output.
REQ-029 Comparisons SHALL be unsigned on the rectified values; output width is W; no overflow is possible.
REQ-030 When conv_fin is high in TOP/BOT, the FSM SHALL enter DONE after any out_valid for that cycle.
REQ-031 DONE: frame_done pulses for one cycle; the FSM returns to IDLE, and out_idx, col and row clear.
REQ-032 When conv_fin and in_valid are high in the same cycle, that pixel SHALL be processed first.
REQ-033 rl<2: the block produces no out_valid; frame_done still pulses on conv_fin.
REQ-034 rl>im: columns at or beyond im SHALL be ignored.
REQ-035 conv_fin high in IDLE SHALL be ignored.

Reset
REQ-036 reset=1 SHALL force state=IDLE, and set out=0, out_valid=0, out_idx=0, frame_done=0, col=0, row=0, hold=0.
REQ-037 reset SHALL NOT clear linebuf; stale contents are never read, because TOP rewrites every entry before BOT reads it.
REQ-038 Reset mid-frame discards the partial frame; the next frame starts at out_idx=0.

Verification
REQ-039 row_len=4; ch0 = 0..15 raster, then conv_fin -> out[0] = 5, 7, 13, 15 at out_idx 0..3; then one frame_done pulse.
REQ-040 row_len=4; ch2 all 0xFFFB (-5) -> 4 pulses with out[2]=0; mixed window {-3, 2, -7, 1} -> 2.
REQ-041 row_len=28; 784 pixels -> exactly 196 out_valid pulses, out_idx 0..195, frame_done once.
REQ-042 Repeat REQ-039 stimulus with in_valid high every third cycle -> identical values and indices.
REQ-043 row_len=5, 4 rows, ch1 = 0..19 -> outputs 6, 8, 16, 18; column 4 never contributes.
REQ-044 Assert reset for one cycle after 10 pixels of REQ-041, then run a full frame -> outputs immediately 0; new frame gives 196 pulses from out_idx 0.
